// File: rtl/cadence_filt_multi.sv
// Multi-channel debounce filter: synchroniser, stability counter, filtered edge pulses.
// Optional per-channel rise-to-rise period measurement when CADENCE_PERIOD_EN is defined.
module cadence_filt_multi #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int FAST_SIM    = 1,
  parameter bit INIT_VAL    = 1'b0,
  parameter int PER_W       = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       sig_in,
  output logic [NUM_CH-1:0]       filt,
  output logic [NUM_CH-1:0]       rise,
  output logic [NUM_CH-1:0]       fall,
  output logic [NUM_CH*PER_W-1:0] period,
  output logic [NUM_CH-1:0]       period_vld
);

  localparam logic [CNT_W-1:0] STBL_MAX =
    (FAST_SIM != 0) ? CNT_W'(511) : {CNT_W{1'b1}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_filt;
    logic                   r_filt_d;
    logic                   w_sync;
    logic                   w_filt_nxt;

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_filt_nxt = (r_cnt == STBL_MAX) ? r_sync_d : r_filt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync   <= {SYNC_STAGES{INIT_VAL}};
        r_sync_d <= INIT_VAL;
        r_cnt    <= '0;
        r_filt   <= INIT_VAL;
        r_filt_d <= INIT_VAL;
      end else begin
        r_sync   <= {r_sync[SYNC_STAGES-2:0], sig_in[g]};
        r_sync_d <= w_sync;
        if (w_sync != r_sync_d)
          r_cnt <= '0;
        else if (r_cnt != STBL_MAX)
          r_cnt <= r_cnt + 1'b1;
        r_filt   <= w_filt_nxt;
        r_filt_d <= r_filt;
      end
    end

    // Both terms registered, so the pulses are glitch-free.
    assign filt[g] = r_filt;
    assign rise[g] = r_filt & ~r_filt_d;
    assign fall[g] = ~r_filt & r_filt_d;

`ifdef CADENCE_PERIOD_EN
    localparam logic [PER_W-1:0] P_MAX = {PER_W{1'b1}};
    logic [PER_W-1:0] r_pcnt;
    logic [PER_W-1:0] r_period;
    logic             r_armed;
    logic             r_pvld;
    logic             w_rise_nxt;

    assign w_rise_nxt = w_filt_nxt & ~r_filt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pcnt   <= '0;
        r_period <= '0;
        r_armed  <= 1'b0;
        r_pvld   <= 1'b0;
      end else if (w_rise_nxt) begin
        r_pcnt  <= '0;
        r_armed <= 1'b1;
        r_pvld  <= r_armed;
        if (r_armed)
          r_period <= (r_pcnt == P_MAX) ? P_MAX : r_pcnt + 1'b1;
      end else begin
        r_pvld <= 1'b0;
        if (r_pcnt != P_MAX)
          r_pcnt <= r_pcnt + 1'b1;
      end
    end

    assign period[g*PER_W +: PER_W] = r_period;
    assign period_vld[g]            = r_pvld;
`else
    assign period[g*PER_W +: PER_W] = '0;
    assign period_vld[g]            = 1'b0;
`endif
  end

endmodule
